// File: rtl/wb_pkg.sv
// wb_pkg: default widths and the pending-entry record shared by the write-back buffer.
package wb_pkg;
  localparam int WB_DATA_WIDTH = 8;
  localparam int WB_ADDR_WIDTH = 3;
  localparam int WB_DEPTH = 4;
  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order entry storage with wrapping pointers and an occupancy count.
module wb_fifo import wb_pkg::*; #(
  parameter type entry_t = wb_entry_t,
  parameter int DEPTH = WB_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  entry_t        din,
  output entry_t        entries [DEPTH],
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [PW-1:0] wr_ptr;
  // Storage needs no reset: every reader qualifies entries with count.
  always_ff @(posedge clk)
    if (push) entries[wr_ptr] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: result queue draining into the register-file write port, with read forwarding.
// Define WB_FORWARD_EN to build the forwarding search; otherwise FWD outputs are tied to 0.
module reg_writeback import wb_pkg::*; #(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic [ADDR_WIDTH-1:0] res_addr,
  input  logic                  rf_hold,
  output logic                  rf_write,
  output logic [DATA_WIDTH-1:0] rf_data,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [ADDR_WIDTH-1:0] fwd1_addr,
  input  logic [ADDR_WIDTH-1:0] fwd2_addr,
  output logic                  fwd1_hit,
  output logic                  fwd2_hit,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic [DATA_WIDTH-1:0] fwd2_data,
  output logic [ADDR_WIDTH:0]   pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = ADDR_WIDTH + 1;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;
  entry_t        entries [DEPTH];
  entry_t        din;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, armed, push;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) armed <= 1'b0;
    else armed <= 1'b1;
  assign din       = {res_addr, res_data};
  assign res_ready = armed && !full;
  assign push      = res_valid && res_ready;
  assign rf_write  = !empty && !rf_hold;
  assign rf_data   = empty ? '0 : entries[rd_ptr].data;
  assign rf_addr   = empty ? '0 : entries[rd_ptr].addr;
  assign pending   = NW'(count);
  wb_fifo #(.entry_t(entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(rf_write), .din(din),
    .entries(entries), .rd_ptr(rd_ptr), .count(count), .full(full), .empty(empty)
  );
`ifdef WB_FORWARD_EN
  logic [ADDR_WIDTH-1:0] fa [2];
  logic                  fh [2];
  logic [DATA_WIDTH-1:0] fd [2];
  assign fa[0] = fwd1_addr;
  assign fa[1] = fwd2_addr;
  // Scan oldest to youngest so the last match, the youngest, wins.
  always_comb
    for (int p = 0; p < 2; p++) begin
      fh[p] = 1'b0;
      fd[p] = '0;
      for (int k = 0; k < DEPTH; k++)
        if (CW'(k) < count && entries[rd_ptr + PW'(k)].addr == fa[p]) begin
          fh[p] = 1'b1;
          fd[p] = entries[rd_ptr + PW'(k)].data;
        end
    end
  assign fwd1_hit  = fh[0];
  assign fwd1_data = fd[0];
  assign fwd2_hit  = fh[1];
  assign fwd2_data = fd[1];
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd1_addr, fwd2_addr};
  assign fwd1_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_hit  = 1'b0;
  assign fwd2_data = '0;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: table vectors, async-reset sequence and randomized queue-model checks.
module tb_reg_writeback;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic       clk = 1'b0, reset_n = 1'b0, res_valid = 1'b0, rf_hold = 1'b0;
  logic [7:0] res_data = '0;
  logic [2:0] res_addr = '0, fwd1_addr = '0, fwd2_addr = '0;
  logic       res_ready, rf_write, fwd1_hit, fwd2_hit;
  logic [7:0] rf_data, fwd1_data, fwd2_data;
  logic [2:0] rf_addr;
  logic [3:0] pending;
  int checks = 0, errors = 0;

  reg_writeback dut (
    .clk(clk), .reset_n(reset_n), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_addr(res_addr), .rf_hold(rf_hold), .rf_write(rf_write),
    .rf_data(rf_data), .rf_addr(rf_addr), .fwd1_addr(fwd1_addr), .fwd2_addr(fwd2_addr),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {logic [2:0] a; logic [7:0] d;} ent_t;
  ent_t mq[$];
  bit   m_armed = 1'b0;
  logic e_ready, e_write, e_h1, e_h2;
  logic [2:0] e_addr;
  logic [7:0] e_data, e_d1, e_d2;
  logic [3:0] e_pend;

  typedef struct {
    logic v; logic [7:0] d; logic [2:0] a; logic h; logic [2:0] f1, f2;
    logic er, ew; logic [2:0] ea; logic [7:0] ed; logic [3:0] ep;
    logic eh1; logic [7:0] ed1; logic eh2;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t row(int v, int d, int a, int h, int f1, int f2, int er, int ew,
                               int ea, int ed, int ep, int eh1, int ed1, int eh2);
    vec_t r;
    r.v = v[0]; r.d = d[7:0]; r.a = a[2:0]; r.h = h[0]; r.f1 = f1[2:0]; r.f2 = f2[2:0];
    r.er = er[0]; r.ew = ew[0]; r.ea = ea[2:0]; r.ed = ed[7:0]; r.ep = ep[3:0];
    r.eh1 = eh1[0]; r.ed1 = ed1[7:0]; r.eh2 = eh2[0];
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask

  // Expected outputs straight from the queue contents and the current inputs.
  task automatic model_expect();
    e_ready = m_armed && mq.size() < 4;
    e_write = mq.size() != 0 && !rf_hold;
    e_addr  = mq.size() != 0 ? mq[0].a : 3'd0;
    e_data  = mq.size() != 0 ? mq[0].d : 8'd0;
    e_pend  = 4'(mq.size());
    e_h1 = 1'b0; e_d1 = '0; e_h2 = 1'b0; e_d2 = '0;
    foreach (mq[i]) begin
      if (FWD && mq[i].a == fwd1_addr) begin e_h1 = 1'b1; e_d1 = mq[i].d; end
      if (FWD && mq[i].a == fwd2_addr) begin e_h2 = 1'b1; e_d2 = mq[i].d; end
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] a, input logic h,
                       input logic [2:0] f1, input logic [2:0] f2);
    res_valid = v; res_data = d; res_addr = a; rf_hold = h; fwd1_addr = f1; fwd2_addr = f2;
    #1;
    model_expect();
  endtask

  task automatic check_model(input string n);
    chk({n, "_ready"}, res_ready, e_ready);
    chk({n, "_write"}, rf_write, e_write);
    chk({n, "_rfaddr"}, rf_addr, e_addr);
    chk({n, "_rfdata"}, rf_data, e_data);
    chk({n, "_pending"}, pending, e_pend);
    chk({n, "_hit1"}, fwd1_hit, e_h1);
    chk({n, "_data1"}, fwd1_data, e_d1);
    chk({n, "_hit2"}, fwd2_hit, e_h2);
    chk({n, "_data2"}, fwd2_data, e_d2);
  endtask

  task automatic tick();
    logic acc, drn;
    ent_t e;
    acc = res_valid && e_ready;
    drn = e_write;
    e.a = res_addr; e.d = res_data;
    @(posedge clk);
    if (reset_n) begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(e);
      m_armed = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    //             v  d     a h f1 f2 er ew ea ed    ep eh1 ed1  eh2
    tbl.push_back(row(1, 'hA5, 3, 0, 7, 5, 0, 0, 0, 'h00, 0, 0, 'h00, 0));
    tbl.push_back(row(1, 'hA5, 3, 0, 7, 5, 1, 0, 0, 'h00, 0, 0, 'h00, 0));
    tbl.push_back(row(0, 'h00, 0, 0, 3, 3, 1, 1, 3, 'hA5, 1, 1, 'hA5, 1));
    tbl.push_back(row(0, 'h00, 0, 0, 3, 5, 1, 0, 0, 'h00, 0, 0, 'h00, 0));
    tbl.push_back(row(1, 'h10, 0, 1, 2, 5, 1, 0, 0, 'h00, 0, 0, 'h00, 0));
    tbl.push_back(row(1, 'h11, 1, 1, 2, 5, 1, 0, 0, 'h10, 1, 0, 'h00, 0));
    tbl.push_back(row(1, 'h12, 2, 1, 2, 5, 1, 0, 0, 'h10, 2, 0, 'h00, 0));
    tbl.push_back(row(1, 'h13, 3, 1, 2, 5, 1, 0, 0, 'h10, 3, 1, 'h12, 0));
    tbl.push_back(row(1, 'h14, 4, 1, 2, 5, 0, 0, 0, 'h10, 4, 1, 'h12, 0));
    tbl.push_back(row(1, 'h14, 4, 0, 2, 5, 0, 1, 0, 'h10, 4, 1, 'h12, 0));
    tbl.push_back(row(1, 'h14, 4, 0, 2, 5, 1, 1, 1, 'h11, 3, 1, 'h12, 0));
    tbl.push_back(row(0, 'h00, 0, 0, 2, 5, 1, 1, 2, 'h12, 3, 1, 'h12, 0));
    tbl.push_back(row(0, 'h00, 0, 0, 2, 5, 1, 1, 3, 'h13, 2, 0, 'h00, 0));
    tbl.push_back(row(0, 'h00, 0, 0, 2, 5, 1, 1, 4, 'h14, 1, 0, 'h00, 0));
    tbl.push_back(row(0, 'h00, 0, 0, 2, 5, 1, 0, 0, 'h00, 0, 0, 'h00, 0));
    tbl.push_back(row(1, 'h11, 2, 1, 2, 5, 1, 0, 0, 'h00, 0, 0, 'h00, 0));
    tbl.push_back(row(1, 'h22, 2, 1, 2, 5, 1, 0, 2, 'h11, 1, 1, 'h11, 0));
    tbl.push_back(row(0, 'h00, 0, 1, 2, 5, 1, 0, 2, 'h11, 2, 1, 'h22, 0));
    tbl.push_back(row(0, 'h00, 0, 0, 2, 5, 1, 1, 2, 'h11, 2, 1, 'h22, 0));
    tbl.push_back(row(0, 'h00, 0, 0, 2, 5, 1, 1, 2, 'h22, 1, 1, 'h22, 0));
    tbl.push_back(row(0, 'h00, 0, 0, 2, 5, 1, 0, 0, 'h00, 0, 0, 'h00, 0));

    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", res_ready, 0);
    chk("rst_write", rf_write, 0);
    chk("rst_rfaddr", rf_addr, 0);
    chk("rst_rfdata", rf_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_hit1", fwd1_hit, 0);
    chk("rst_data1", fwd1_data, 0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].a, tbl[i].h, tbl[i].f1, tbl[i].f2);
      chk($sformatf("t%0d_ready", i), res_ready, tbl[i].er);
      chk($sformatf("t%0d_write", i), rf_write, tbl[i].ew);
      chk($sformatf("t%0d_rfaddr", i), rf_addr, tbl[i].ea);
      chk($sformatf("t%0d_rfdata", i), rf_data, tbl[i].ed);
      chk($sformatf("t%0d_pending", i), pending, tbl[i].ep);
      chk($sformatf("t%0d_hit1", i), fwd1_hit, FWD ? tbl[i].eh1 : 1'b0);
      chk($sformatf("t%0d_data1", i), fwd1_data, FWD ? tbl[i].ed1 : 8'h00);
      chk($sformatf("t%0d_hit2", i), fwd2_hit, FWD ? tbl[i].eh2 : 1'b0);
      tick();
    end

    for (int i = 0; i < 18; i++) begin
      drive(i < 16, 8'(i * 7 + 1), 3'(i), 1'b0, 3'(i), 3'(i + 1));
      check_model($sformatf("s%0d", i));
      tick();
    end

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h30 + i), 3'(i + 5), 1'b1, 3'd5, 3'd6);
      check_model($sformatf("f%0d", i));
      tick();
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 3'd5, 3'd6);
    check_model("pre_ar");
    #2 reset_n = 1'b0;
    #1;
    chk("ar_write", rf_write, 0);
    chk("ar_pending", pending, 0);
    chk("ar_ready", res_ready, 0);
    chk("ar_hit1", fwd1_hit, 0);
    mq.delete();
    m_armed = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 3'd0, 1'b0, 3'd5, 3'd6);
      check_model($sformatf("post_ar%0d", i));
      tick();
    end

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3) != 0, 8'($urandom), 3'($urandom), $urandom_range(2) == 0,
            3'($urandom), 3'($urandom));
      check_model($sformatf("r%0d", i));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
